// File: rtl/drum_timing.sv
// drum_timing: bit-time / word-time generator for a rotating drum memory.
// Optional revolution counter when DRUM_TIMING_REV_COUNT_EN is defined.
//
// Ports:
//   clk        in   system bit clock; all state changes on its rising edge
//   rst        in   asynchronous active-high reset
//   tick       in   one-clk advance strobe from the upstream timer
//   resync     in   synchronous restart of drum position to T0/L0
//   bit_time   out  [4:0] current bit time T0..T(BITS_PER_WORD-1)
//   word_time  out  [6:0] current word time L0..L(WORDS_PER_REV-1)
//   t0         out  high while bit_time == 0
//   tlast      out  high while bit_time == BITS_PER_WORD-1
//   word_even  out  high while word_time is even
//   rev_pulse  out  one-clk pulse at the start of a new revolution
//   rev_count  out  [15:0] revolutions seen (only with DRUM_TIMING_REV_COUNT_EN)

module drum_timing #(
    parameter int BITS_PER_WORD = 29,
    parameter int WORDS_PER_REV = 108
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       resync,
    output logic [4:0] bit_time,
    output logic [6:0] word_time,
    output logic       t0,
    output logic       tlast,
    output logic       word_even,
`ifdef DRUM_TIMING_REV_COUNT_EN
    output logic       rev_pulse,
    output logic [15:0] rev_count
`else
    output logic       rev_pulse
`endif
);

    // Reject configurations the 5/7-bit output fields cannot represent.
    generate
        if (BITS_PER_WORD < 2 || BITS_PER_WORD > 32) begin : g_bad_bits
            $error("drum_timing: BITS_PER_WORD out of range 2..32");
        end
        if (WORDS_PER_REV < 2 || WORDS_PER_REV > 128) begin : g_bad_words
            $error("drum_timing: WORDS_PER_REV out of range 2..128");
        end
    endgenerate

    localparam logic [4:0] LP_BIT_LAST  = 5'(BITS_PER_WORD - 1);
    localparam logic [6:0] LP_WORD_LAST = 7'(WORDS_PER_REV - 1);

    logic [4:0] r_bit;
    logic [6:0] r_word;
    logic       r_rev_pulse;

    logic [4:0] w_bit_nxt;
    logic [6:0] w_word_nxt;
    logic       w_rev_nxt;
    logic       w_bit_wrap;
    logic       w_word_wrap;

    // Compare with >= so any out-of-range value falls back to 0 on the
    // next tick instead of counting up through illegal states.
    assign w_bit_wrap  = (r_bit >= LP_BIT_LAST);
    assign w_word_wrap = (r_word >= LP_WORD_LAST);

    always_comb begin
        w_bit_nxt  = r_bit;
        w_word_nxt = r_word;
        w_rev_nxt  = 1'b0;
        if (resync) begin
            // Restart beats tick and never announces a revolution.
            w_bit_nxt  = 5'd0;
            w_word_nxt = 7'd0;
        end else if (tick) begin
            if (w_bit_wrap) begin
                w_bit_nxt = 5'd0;
                if (w_word_wrap) begin
                    w_word_nxt = 7'd0;
                    w_rev_nxt  = 1'b1;
                end else begin
                    w_word_nxt = r_word + 7'd1;
                end
            end else begin
                w_bit_nxt = r_bit + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit       <= 5'd0;
            r_word      <= 7'd0;
            r_rev_pulse <= 1'b0;
        end else begin
            r_bit       <= w_bit_nxt;
            r_word      <= w_word_nxt;
            r_rev_pulse <= w_rev_nxt;
        end
    end

`ifdef DRUM_TIMING_REV_COUNT_EN
    logic [15:0] r_rev_count;

    // Counts on the same edge that raises rev_pulse; resync leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rev_count <= 16'd0;
        end else if (w_rev_nxt) begin
            r_rev_count <= r_rev_count + 16'd1;
        end
    end

    assign rev_count = r_rev_count;
`endif

    // Status flags decoded from registered state only.
    assign bit_time  = r_bit;
    assign word_time = r_word;
    assign t0        = (r_bit == 5'd0);
    assign tlast     = (r_bit == LP_BIT_LAST);
    assign word_even = ~r_word[0];
    assign rev_pulse = r_rev_pulse;

endmodule

// File: tb/tb_drum_timing.sv
// tb_drum_timing: randomized self-checking bench for drum_timing.
// Reference model tracks drum position as a single linear index.

`timescale 1ns/1ps

module tb_drum_timing;

    localparam int BPW   = 29;
    localparam int WPR   = 108;
    localparam int TOTAL = BPW * WPR;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       resync;
    logic [4:0] bit_time;
    logic [6:0] word_time;
    logic       t0;
    logic       tlast;
    logic       word_even;
    logic       rev_pulse;
`ifdef DRUM_TIMING_REV_COUNT_EN
    logic [15:0] rev_count;
`endif

    int errors;
    int checks;

    // Model state: linear position in the revolution, pulse, revolutions.
    int m_pos;
    bit m_pulse;
    int m_revs;

    drum_timing #(
        .BITS_PER_WORD(BPW),
        .WORDS_PER_REV(WPR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .resync   (resync),
        .bit_time (bit_time),
        .word_time(word_time),
        .t0       (t0),
        .tlast    (tlast),
        .word_even(word_even),
`ifdef DRUM_TIMING_REV_COUNT_EN
        .rev_pulse(rev_pulse),
        .rev_count(rev_count)
`else
        .rev_pulse(rev_pulse)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_vec();
        int eb;
        int ew;
        eb = m_pos % BPW;
        ew = m_pos / BPW;
        return {5'(eb), 7'(ew), (eb == 0), (eb == BPW - 1),
                ((ew % 2) == 0), m_pulse};
    endfunction

    function automatic logic [15:0] got_vec();
        return {bit_time, word_time, t0, tlast, word_even, rev_pulse};
    endfunction

    // One clock with the given inputs; model updated at the edge,
    // returns at the following falling edge.
    task automatic drive(input logic t, input logic r);
        tick   = t;
        resync = r;
        @(posedge clk);
        if (r) begin
            m_pos   = 0;
            m_pulse = 0;
        end else if (t) begin
            m_pos = m_pos + 1;
            if (m_pos == TOTAL) begin
                m_pos   = 0;
                m_pulse = 1;
                m_revs  = m_revs + 1;
            end else begin
                m_pulse = 0;
            end
        end else begin
            m_pulse = 0;
        end
        @(negedge clk);
        tick   = 1'b0;
        resync = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        m_pos   = 0;
        m_pulse = 0;
        m_revs  = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        tick   = 1'b0;
        resync = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (got_vec() !== {5'd0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=%h", got_vec(),
                     {5'd0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        rst     = 1'b0;
        m_pos   = 0;
        m_pulse = 0;
        m_revs  = 0;
        @(negedge clk);
        checks++;
        if (got_vec() !== {5'd0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_release got=%h exp=%h", got_vec(),
                     {5'd0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
`ifdef DRUM_TIMING_REV_COUNT_EN
        checks++;
        if (rev_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_rev_count got=%0d exp=0", rev_count);
        end
`endif
        drive(1'b1, 1'b0);
        checks++;
        if (bit_time !== 5'd1 || word_time !== 7'd0) begin
            errors++;
            $display("FAIL first_tick got=T%0d/L%0d exp=T1/L0",
                     bit_time, word_time);
        end
    endtask

    task automatic test_word_wrap();
        do_reset();
        repeat (28) drive(1'b1, 1'b0);
        checks++;
        if (tlast !== 1'b1 || bit_time !== 5'd28 || t0 !== 1'b0) begin
            errors++;
            $display("FAIL tlast_at_28 got=T%0d tlast=%b t0=%b exp=T28 1 0",
                     bit_time, tlast, t0);
        end
        drive(1'b1, 1'b0);
        checks++;
        if (bit_time !== 5'd0 || word_time !== 7'd1 ||
            word_even !== 1'b0 || t0 !== 1'b1 || tlast !== 1'b0) begin
            errors++;
            $display("FAIL word_wrap got=T%0d/L%0d even=%b exp=T0/L1 even=0",
                     bit_time, word_time, word_even);
        end
    endtask

    task automatic test_revolution();
        int pulses;
        int pulse_at;
        do_reset();
        pulses   = 0;
        pulse_at = -1;
        for (int i = 1; i <= TOTAL; i++) begin
            drive(1'b1, 1'b0);
            if (rev_pulse === 1'b1) begin
                pulses++;
                pulse_at = i;
            end
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rev_step%0d got=%h exp=%h", i,
                         got_vec(), exp_vec());
            end
        end
        checks++;
        if (pulses != 1 || pulse_at != TOTAL) begin
            errors++;
            $display("FAIL rev_pulse_count got=%0d@%0d exp=1@%0d",
                     pulses, pulse_at, TOTAL);
        end
        checks++;
        if (bit_time !== 5'd0 || word_time !== 7'd0) begin
            errors++;
            $display("FAIL rev_position got=T%0d/L%0d exp=T0/L0",
                     bit_time, word_time);
        end
`ifdef DRUM_TIMING_REV_COUNT_EN
        checks++;
        if (rev_count !== 16'd1) begin
            errors++;
            $display("FAIL rev_count got=%0d exp=1", rev_count);
        end
`endif
        drive(1'b0, 1'b0);
        checks++;
        if (rev_pulse !== 1'b0) begin
            errors++;
            $display("FAIL rev_pulse_width got=%b exp=0", rev_pulse);
        end
    endtask

    task automatic test_resync();
`ifdef DRUM_TIMING_REV_COUNT_EN
        logic [15:0] rc_before;
`endif
        do_reset();
        repeat (50 * BPW + 10) drive(1'b1, 1'b0);
        checks++;
        if (bit_time !== 5'd10 || word_time !== 7'd50) begin
            errors++;
            $display("FAIL resync_setup got=T%0d/L%0d exp=T10/L50",
                     bit_time, word_time);
        end
`ifdef DRUM_TIMING_REV_COUNT_EN
        rc_before = rev_count;
`endif
        drive(1'b1, 1'b1);
        checks++;
        if (got_vec() !== {5'd0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL resync_priority got=%h exp=%h", got_vec(),
                     {5'd0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        // Resync exactly where the next tick would complete a revolution.
        repeat (TOTAL - 1) drive(1'b1, 1'b0);
        checks++;
        if (bit_time !== 5'(BPW - 1) || word_time !== 7'(WPR - 1)) begin
            errors++;
            $display("FAIL resync_wrap_setup got=T%0d/L%0d exp=T28/L107",
                     bit_time, word_time);
        end
        drive(1'b1, 1'b1);
        checks++;
        if (rev_pulse !== 1'b0 || bit_time !== 5'd0 ||
            word_time !== 7'd0) begin
            errors++;
            $display("FAIL resync_no_pulse got=%b T%0d/L%0d exp=0 T0/L0",
                     rev_pulse, bit_time, word_time);
        end
`ifdef DRUM_TIMING_REV_COUNT_EN
        checks++;
        if (rev_count !== rc_before) begin
            errors++;
            $display("FAIL resync_rev_count got=%0d exp=%0d",
                     rev_count, rc_before);
        end
`endif
    endtask

    task automatic test_sparse();
        logic [15:0] snap;
        do_reset();
        for (int n = 0; n < 100; n++) begin
            drive(1'b1, 1'b0);
            snap = got_vec();
            for (int k = 0; k < 4; k++) begin
                drive(1'b0, 1'b0);
                checks++;
                if (got_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL sparse_hold n=%0d got=%h exp=%h", n,
                             got_vec(), exp_vec());
                end
            end
            checks++;
            if ({snap[15:1], 1'b0} !== {got_vec()[15:1], 1'b0}) begin
                errors++;
                $display("FAIL sparse_stable n=%0d got=%h exp=%h", n,
                         got_vec(), snap);
            end
        end
        checks++;
        if (bit_time !== 5'd13 || word_time !== 7'd3) begin
            errors++;
            $display("FAIL sparse_final got=T%0d/L%0d exp=T13/L3",
                     bit_time, word_time);
        end
    endtask

    task automatic test_random();
        logic t;
        logic r;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            t = 1'($urandom_range(0, 3) != 0);
            r = 1'($urandom_range(0, 299) == 0);
            drive(t, r);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_step%0d got=%h exp=%h", i,
                         got_vec(), exp_vec());
            end
`ifdef DRUM_TIMING_REV_COUNT_EN
            checks++;
            if (rev_count !== 16'(m_revs)) begin
                errors++;
                $display("FAIL random_rev_count%0d got=%0d exp=%0d", i,
                         rev_count, m_revs);
            end
`endif
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (107 * BPW + 20) drive(1'b1, 1'b0);
        checks++;
        if (bit_time !== 5'd20 || word_time !== 7'd107) begin
            errors++;
            $display("FAIL async_setup got=T%0d/L%0d exp=T20/L107",
                     bit_time, word_time);
        end
        tick = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (got_vec() !== {5'd0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", got_vec(),
                     {5'd0, 7'd0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
`ifdef DRUM_TIMING_REV_COUNT_EN
        checks++;
        if (rev_count !== 16'd0) begin
            errors++;
            $display("FAIL async_rev_count got=%0d exp=0", rev_count);
        end
`endif
        tick = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
        m_pos   = 0;
        m_pulse = 0;
        m_revs  = 0;
        @(negedge clk);
        drive(1'b1, 1'b0);
        checks++;
        if (bit_time !== 5'd1 || word_time !== 7'd0) begin
            errors++;
            $display("FAIL after_async_tick got=T%0d/L%0d exp=T1/L0",
                     bit_time, word_time);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_pos   = 0;
        m_pulse = 0;
        m_revs  = 0;
        rst    = 1'b1;
        tick   = 1'b0;
        resync = 1'b0;
        test_reset();
        test_word_wrap();
        test_revolution();
        test_resync();
        test_sparse();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
